// File: rtl/bsg_comm_link_pkg.sv
// Shared limits and helper functions for the comm-link retiming pipe.
// Both stage chains and the calib delay line are sized from these.
package bsg_comm_link_pkg;

    localparam int retime_stages_max_lp = 8;
    localparam int retime_calib_max_lp  = 4;

    // Occupancy of N two-entry stages spans 0..2N.
    function automatic int retime_cnt_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    function automatic bit retime_params_legal(input int in_stages,
                                               input int out_stages,
                                               input int calib_depth);
        return (in_stages  >= 1) && (in_stages  <= retime_stages_max_lp) &&
               (out_stages >= 1) && (out_stages <= retime_stages_max_lp) &&
               (calib_depth >= 1) && (calib_depth <= retime_calib_max_lp);
    endfunction

endpackage

// File: rtl/bsg_two_fifo_arn.sv
// Two-entry FIFO with async active-low reset and synchronous clear.
// A full FIFO that is dequeued accepts a new word in the same cycle.
module bsg_two_fifo_arn #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o
);
    logic               head_r;
    logic               tail_r;
    logic               full_r;
    logic [width_p-1:0] mem_r [2];
    logic               enq;
    logic               deq;
    logic               one;

    assign one     = head_r ^ tail_r;
    assign v_o     = full_r | one;
    assign ready_o = ~full_r | yumi_i;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[head_r];
    assign count_o = full_r ? 2'd2 : {1'b0, one};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
            full_r <= 1'b0;
        end else if (clear_i) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
            full_r <= 1'b0;
        end else begin
            if (enq) tail_r <= ~tail_r;
            if (deq) head_r <= ~head_r;
            full_r <= full_r ? (~deq | enq) : (enq & ~deq & one);
        end
    end

    // Storage is deliberately unreset; v_o qualifies it.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[tail_r] <= data_i;
    end

endmodule

// File: rtl/bsg_comm_link_retime_pipe.sv
// Per-channel retiming chains between link kernel and fuser, in both directions.
// A channel is live only when delayed calib_done and its active bit are both set.
module bsg_comm_link_retime_pipe
    import bsg_comm_link_pkg::*;
#(
    parameter int channel_width_p    = 16,
    parameter int link_channels_p    = 4,
    parameter int in_stages_p        = 2,
    parameter int out_stages_p       = 2,
    parameter int calib_pipe_depth_p = 2
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_n_i,
    input  logic                                                   calib_done_i,
    input  logic [link_channels_p-1:0]                             active_channels_i,
    input  logic [link_channels_p-1:0]                             in_v_i,
    input  logic [link_channels_p*channel_width_p-1:0]             in_data_i,
    output logic [link_channels_p-1:0]                             in_yumi_o,
    output logic [link_channels_p-1:0]                             in_v_o,
    output logic [link_channels_p*channel_width_p-1:0]             in_data_o,
    input  logic [link_channels_p-1:0]                             in_yumi_i,
    input  logic [link_channels_p-1:0]                             out_v_i,
    input  logic [link_channels_p*channel_width_p-1:0]             out_data_i,
    output logic [link_channels_p-1:0]                             out_ready_o,
    output logic [link_channels_p-1:0]                             out_v_o,
    output logic [link_channels_p*channel_width_p-1:0]             out_data_o,
    input  logic [link_channels_p-1:0]                             out_ready_i,
    output logic [link_channels_p*retime_cnt_width(in_stages_p)-1:0]  in_count_o,
    output logic [link_channels_p*retime_cnt_width(out_stages_p)-1:0] out_count_o,
    output logic                                                   idle_o
);
    localparam int in_cnt_w_lp  = retime_cnt_width(in_stages_p);
    localparam int out_cnt_w_lp = retime_cnt_width(out_stages_p);
    localparam bit params_ok_lp = retime_params_legal(in_stages_p, out_stages_p,
                                                      calib_pipe_depth_p);

    if (!params_ok_lp) begin : g_bad_params
        $error("bsg_comm_link_retime_pipe: stage or calib depth out of range");
    end

    logic [calib_pipe_depth_p-1:0] calib_r;
    logic [link_channels_p-1:0]    chan_en;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) calib_r <= '0;
        else            calib_r <= (calib_r << 1) | calib_pipe_depth_p'(calib_done_i);
    end

    assign chan_en = {link_channels_p{calib_r[calib_pipe_depth_p-1]}} & active_channels_i;

    for (genvar c = 0; c < link_channels_p; c++) begin : g_chan
        logic en;
        assign en = chan_en[c];

        // Inbound: kernel (valid-then-yumi) -> fuser (valid-then-yumi).
        for (genvar k = 0; k < in_stages_p; k++) begin : g_in
            logic                       up_v;
            logic [channel_width_p-1:0] up_data;
            logic                       ready;
            logic                       v;
            logic [channel_width_p-1:0] data;
            logic                       deq;
            logic [1:0]                 cnt;
            logic [in_cnt_w_lp-1:0]     acc;

            if (k == 0) begin : g_first
                assign up_v    = in_v_i[c] & en;
                assign up_data = in_data_i[c*channel_width_p +: channel_width_p];
                assign acc     = in_cnt_w_lp'(cnt);
            end else begin : g_next
                assign up_v    = g_in[k-1].v;
                assign up_data = g_in[k-1].data;
                assign acc     = g_in[k-1].acc + in_cnt_w_lp'(cnt);
            end

            if (k == in_stages_p - 1) begin : g_last
                assign deq = in_yumi_i[c] & v & en;
            end else begin : g_mid
                assign deq = v & g_in[k+1].ready;
            end

            bsg_two_fifo_arn #(.width_p(channel_width_p)) u_fifo (
                .clk_i    (clk_i),
                .reset_n_i(reset_n_i),
                .clear_i  (~en),
                .v_i      (up_v),
                .data_i   (up_data),
                .ready_o  (ready),
                .v_o      (v),
                .data_o   (data),
                .yumi_i   (deq),
                .count_o  (cnt)
            );
        end

        assign in_yumi_o[c] = in_v_i[c] & g_in[0].ready & en;
        assign in_v_o[c]    = g_in[in_stages_p-1].v & en;
        assign in_data_o[c*channel_width_p +: channel_width_p] = g_in[in_stages_p-1].data;
        assign in_count_o[c*in_cnt_w_lp +: in_cnt_w_lp]        = g_in[in_stages_p-1].acc;

        // Outbound: fuser (ready/valid) -> kernel (ready/valid).
        for (genvar k = 0; k < out_stages_p; k++) begin : g_out
            logic                       up_v;
            logic [channel_width_p-1:0] up_data;
            logic                       ready;
            logic                       v;
            logic [channel_width_p-1:0] data;
            logic                       deq;
            logic [1:0]                 cnt;
            logic [out_cnt_w_lp-1:0]    acc;

            if (k == 0) begin : g_first
                assign up_v    = out_v_i[c] & en;
                assign up_data = out_data_i[c*channel_width_p +: channel_width_p];
                assign acc     = out_cnt_w_lp'(cnt);
            end else begin : g_next
                assign up_v    = g_out[k-1].v;
                assign up_data = g_out[k-1].data;
                assign acc     = g_out[k-1].acc + out_cnt_w_lp'(cnt);
            end

            if (k == out_stages_p - 1) begin : g_last
                assign deq = out_ready_i[c] & v & en;
            end else begin : g_mid
                assign deq = v & g_out[k+1].ready;
            end

            bsg_two_fifo_arn #(.width_p(channel_width_p)) u_fifo (
                .clk_i    (clk_i),
                .reset_n_i(reset_n_i),
                .clear_i  (~en),
                .v_i      (up_v),
                .data_i   (up_data),
                .ready_o  (ready),
                .v_o      (v),
                .data_o   (data),
                .yumi_i   (deq),
                .count_o  (cnt)
            );
        end

        assign out_ready_o[c] = g_out[0].ready & en;
        assign out_v_o[c]     = g_out[out_stages_p-1].v & en;
        assign out_data_o[c*channel_width_p +: channel_width_p] = g_out[out_stages_p-1].data;
        assign out_count_o[c*out_cnt_w_lp +: out_cnt_w_lp]      = g_out[out_stages_p-1].acc;
    end

    assign idle_o = ~(|in_count_o) & ~(|out_count_o);

endmodule
